// File: rtl/reg_writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_unit_pkg
// Brief   : Shared widths, default depth and the write-back entry record.
// Revision: 1.0 - initial release
// ============================================================================
package reg_writeback_unit_pkg;

  localparam int C_DATA_W = 8;
  localparam int C_ADDR_W = 4;
  localparam int C_DEPTH  = 4;

  typedef struct packed {
    logic [C_ADDR_W-1:0] addr;
    logic [C_DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_unit_if
// Brief   : Load/ALU request channels and register-file write port.
// Revision: 1.0 - initial release
// ============================================================================
interface reg_writeback_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              wr_hold;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data, wr_hold, flush,
    input  ld_ready, alu_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data, wr_hold, flush,
    output ld_ready, alu_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_unit_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : Circular write-back queue exposing every slot plus an occupancy mask.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int  DEPTH   = C_DEPTH,
  parameter type ENTRY_T = wb_entry_t
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         i_flush,
  input  wire logic                         i_push,
  input  wire ENTRY_T                       i_push_entry,
  input  wire logic                         i_pop,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(DEPTH+1)-1:0]        o_count,
  output ENTRY_T                            o_head,
  output ENTRY_T [DEPTH-1:0]                o_entries,
  output logic [DEPTH-1:0]                  o_occupied
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

  ENTRY_T             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_full  = (r_count == c_full_cnt);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] w_offs;
    assign w_offs        = PTR_W'(i) - r_rd_ptr;
    assign o_occupied[i] = (CNT_W'(w_offs) < r_count);
    assign o_entries[i]  = r_mem[i];
  end
endmodule
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_unit
// Brief   : Arbitrates load/ALU results into a queue and drains it to the RF.
// Revision: 1.0 - initial release
// ============================================================================
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH  = C_DEPTH,
  parameter int DATA_W = C_DATA_W,
  parameter int ADDR_W = C_ADDR_W
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  reg_writeback_unit_if.slave             bus,
  input  wire logic [ADDR_W-1:0]          query_addr_A,
  input  wire logic [ADDR_W-1:0]          query_addr_B,
  output logic                            pending_A,
  output logic                            pending_B,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_count
);
  // Same layout as wb_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_ld_ready;
  logic                 w_alu_ready;
  logic                 w_ld_push;
  logic                 w_push;
  logic                 w_wr_en;
  logic                 w_pend_a;
  logic                 w_pend_b;
  entry_t               w_push_entry;
  entry_t               w_head;
  entry_t [DEPTH-1:0]   w_entries;
  logic [DEPTH-1:0]     w_occ;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (bus.flush),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_wr_en),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (fifo_count),
    .o_head       (w_head),
    .o_entries    (w_entries),
    .o_occupied   (w_occ)
  );

  // Readies read high in reset; the held-in-reset FIFO ignores any push anyway.
  always_comb begin
    w_ld_ready   = !reset || (!w_full && !bus.flush);
    w_alu_ready  = !reset || (!w_full && !bus.flush && !bus.ld_valid);
    w_ld_push    = bus.ld_valid && w_ld_ready;
    w_push       = w_ld_push || (bus.alu_valid && w_alu_ready);
    w_push_entry = w_ld_push ? entry_t'{addr: bus.ld_addr,  data: bus.ld_data}
                             : entry_t'{addr: bus.alu_addr, data: bus.alu_data};
    w_wr_en      = !w_empty && !bus.wr_hold;
  end

  always_comb begin
    w_pend_a = 1'b0;
    w_pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occ[i] && (w_entries[i].addr == query_addr_A)) w_pend_a = 1'b1;
      if (w_occ[i] && (w_entries[i].addr == query_addr_B)) w_pend_b = 1'b1;
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.alu_ready = w_alu_ready;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_addr   = w_empty ? '0 : w_head.addr;
  assign bus.wr_data   = w_empty ? '0 : w_head.data;
  assign pending_A     = w_pend_a;
  assign pending_B     = w_pend_b;
endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_writeback_unit
// Brief   : Vector table plus queue scoreboard for reg_writeback_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_writeback_unit;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [3:0] query_addr_A;
  logic [3:0] query_addr_B;
  logic       pending_A;
  logic       pending_B;
  logic [2:0] fifo_count;

  reg_writeback_unit_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  reg_writeback_unit #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .query_addr_A (query_addr_A),
    .query_addr_B (query_addr_B),
    .pending_A    (pending_A),
    .pending_B    (pending_B),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the modelled queue contents, oldest first.
  typedef struct { logic [3:0] a; logic [7:0] d; } sb_t;
  sb_t sb[$];
  logic m_ldr, m_alur, m_wen, m_pa, m_pb;

  always @(negedge reset) sb.delete();

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      m_ldr  = (sb.size() != DEPTH) && !bus.flush;
      m_alur = m_ldr && !bus.ld_valid;
      m_wen  = (sb.size() != 0) && !bus.wr_hold;
      m_pa   = 1'b0;
      m_pb   = 1'b0;
      foreach (sb[i]) begin
        if (sb[i].a == query_addr_A) m_pa = 1'b1;
        if (sb[i].a == query_addr_B) m_pb = 1'b1;
      end
      chk("sb_ld_ready",  bus.ld_ready,  m_ldr);
      chk("sb_alu_ready", bus.alu_ready, m_alur);
      chk("sb_wr_en",     bus.wr_en,     m_wen);
      chk("sb_count",     fifo_count,    32'(sb.size()));
      chk("sb_pending_A", pending_A,     m_pa);
      chk("sb_pending_B", pending_B,     m_pb);
      if (m_wen) begin
        chk("sb_wr_addr", bus.wr_addr, sb[0].a);
        chk("sb_wr_data", bus.wr_data, sb[0].d);
        n_writes++;
        void'(sb.pop_front());
      end
      if (bus.flush) sb.delete();
      else if (bus.ld_valid && m_ldr) sb.push_back('{bus.ld_addr, bus.ld_data});
      else if (bus.alu_valid && m_alur) sb.push_back('{bus.alu_addr, bus.alu_data});
    end
  end

  typedef struct {
    logic ldv; logic [3:0] lda; logic [7:0] ldd;
    logic aluv; logic [3:0] alua; logic [7:0] alud;
    logic hold; logic flush;
    logic e_ldr; logic e_alur; logic e_wen; logic [3:0] e_wa; logic [7:0] e_wd;
    logic [2:0] e_cnt; logic e_pa; logic e_pb;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic ldv, input logic [3:0] lda, input logic [7:0] ldd,
                     input logic aluv, input logic [3:0] alua, input logic [7:0] alud,
                     input logic hold, input logic flush, input logic e_ldr, input logic e_alur,
                     input logic e_wen, input logic [3:0] e_wa, input logic [7:0] e_wd,
                     input logic [2:0] e_cnt, input logic e_pa, input logic e_pb);
    vec_t v;
    v = '{ldv, lda, ldd, aluv, alua, alud, hold, flush,
          e_ldr, e_alur, e_wen, e_wa, e_wd, e_cnt, e_pa, e_pb};
    vq.push_back(v);
  endtask

  task automatic drive(input logic ldv, input logic [3:0] lda, input logic [7:0] ldd,
                       input logic hold);
    bus.ld_valid  = ldv;
    bus.ld_addr   = lda;
    bus.ld_data   = ldd;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.wr_hold   = hold;
    bus.flush     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int w0;

  initial begin
    reset = 1'b0;
    query_addr_A = 4'h7;
    query_addr_B = 4'h6;
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    #2;
    chk("rst_wr_en",     bus.wr_en,     1'b0);
    chk("rst_count",     fifo_count,    3'd0);
    chk("rst_ld_ready",  bus.ld_ready,  1'b1);
    chk("rst_alu_ready", bus.alu_ready, 1'b1);
    chk("rst_wr_addr",   bus.wr_addr,   4'h0);
    @(posedge clk);
    #3 reset = 1'b1;

    //  ldv lda  ldd    aluv alua alud  hold fl  ldr alur wen wa   wd     cnt pa pb
    add(1, 4'h3, 8'h5A, 0, 4'h0, 8'h00, 0, 0,  1, 0,   0, 4'h0, 8'h00, 0, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   1, 4'h3, 8'h5A, 1, 0, 0);
    add(1, 4'h2, 8'h11, 1, 4'h4, 8'h22, 0, 0,  1, 0,   0, 4'h0, 8'h00, 0, 0, 0);
    add(0, 4'h0, 8'h00, 1, 4'h4, 8'h22, 0, 0,  1, 1,   1, 4'h2, 8'h11, 1, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   1, 4'h4, 8'h22, 1, 0, 0);
    add(1, 4'h7, 8'hAA, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h0, 8'h00, 0, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 0,  1, 1,   0, 4'h7, 8'hAA, 1, 1, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   1, 4'h7, 8'hAA, 1, 1, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   0, 4'h0, 8'h00, 0, 0, 0);
    add(1, 4'h1, 8'h01, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h0, 8'h00, 0, 0, 0);
    add(1, 4'h2, 8'h02, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h1, 8'h01, 1, 0, 0);
    add(1, 4'h3, 8'h03, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h1, 8'h01, 2, 0, 0);
    add(1, 4'h4, 8'h04, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h1, 8'h01, 3, 0, 0);
    add(1, 4'h5, 8'h05, 0, 4'h0, 8'h00, 1, 0,  0, 0,   0, 4'h1, 8'h01, 4, 0, 0);
    add(1, 4'h6, 8'h06, 0, 4'h0, 8'h00, 0, 0,  0, 0,   1, 4'h1, 8'h01, 4, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   1, 4'h2, 8'h02, 3, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   1, 4'h3, 8'h03, 2, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   1, 4'h4, 8'h04, 1, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   0, 4'h0, 8'h00, 0, 0, 0);
    add(1, 4'h9, 8'h09, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h0, 8'h00, 0, 0, 0);
    add(1, 4'hA, 8'h0A, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h9, 8'h09, 1, 0, 0);
    add(1, 4'hB, 8'h0B, 0, 4'h0, 8'h00, 1, 0,  1, 0,   0, 4'h9, 8'h09, 2, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 1,  0, 0,   1, 4'h9, 8'h09, 3, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   0, 4'h0, 8'h00, 0, 0, 0);
    add(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0,  1, 1,   0, 4'h0, 8'h00, 0, 0, 0);

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clk);
      #1;
      bus.ld_valid  = vq[k].ldv;
      bus.ld_addr   = vq[k].lda;
      bus.ld_data   = vq[k].ldd;
      bus.alu_valid = vq[k].aluv;
      bus.alu_addr  = vq[k].alua;
      bus.alu_data  = vq[k].alud;
      bus.wr_hold   = vq[k].hold;
      bus.flush     = vq[k].flush;
      #2;
      chk($sformatf("v%0d_ld_ready", k),  bus.ld_ready,  vq[k].e_ldr);
      chk($sformatf("v%0d_alu_ready", k), bus.alu_ready, vq[k].e_alur);
      chk($sformatf("v%0d_wr_en", k),     bus.wr_en,     vq[k].e_wen);
      chk($sformatf("v%0d_wr_addr", k),   bus.wr_addr,   vq[k].e_wa);
      chk($sformatf("v%0d_wr_data", k),   bus.wr_data,   vq[k].e_wd);
      chk($sformatf("v%0d_count", k),     fifo_count,    vq[k].e_cnt);
      chk($sformatf("v%0d_pending_A", k), pending_A,     vq[k].e_pa);
      chk($sformatf("v%0d_pending_B", k), pending_B,     vq[k].e_pb);
    end

    // Back-to-back push/pop pairs walk the pointers around the ring twice.
    w0 = n_writes;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 drive(1'b1, 4'(k), 8'h30 + 8'(k), 1'b0);
      #2 chk("wrap_count_le1", (fifo_count <= 3'd1), 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 drive(1'b0, 4'h0, 8'h00, 1'b0);
    end
    #2;
    chk("wrap_writes", n_writes - w0, 10);
    chk("wrap_drained", fifo_count, 3'd0);

    // Reset asserted while a queue of three is draining.
    query_addr_A = 4'hD;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 drive(1'b1, 4'hC + 4'(k), 8'hC0 + 8'(k), 1'b1);
    end
    @(posedge clk);
    #1 drive(1'b0, 4'h0, 8'h00, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 4'h1, 8'hEE, 1'b0);
    #1;
    chk("pre_rst_wr_en",     bus.wr_en,  1'b1);
    chk("pre_rst_pending_A", pending_A,  1'b1);
    reset = 1'b0;
    #1;
    chk("arst_wr_en",     bus.wr_en,     1'b0);
    chk("arst_count",     fifo_count,    3'd0);
    chk("arst_wr_addr",   bus.wr_addr,   4'h0);
    chk("arst_wr_data",   bus.wr_data,   8'h00);
    chk("arst_pending_A", pending_A,     1'b0);
    chk("arst_ld_ready",  bus.ld_ready,  1'b1);
    chk("arst_alu_ready", bus.alu_ready, 1'b1);
    @(posedge clk);
    #1 chk("arst_no_accept", fifo_count, 3'd0);
    drive(1'b0, 4'h0, 8'h00, 1'b0);
    #2 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #3;
      chk("post_rst_wr_en", bus.wr_en,  1'b0);
      chk("post_rst_count", fifo_count, 3'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
